mux_lp_nch: RTL and testbench
=============================

// Module: mux_lp_nch
// PURPOSE
// - N-channel, W-bit low-power multiplexer. Successor to the 2:1 single-bit pulsed-power mux.
// - Registered output with a valid/ready handshake. Output register is data-gated: it loads only when the selected value differs from Y.
// - An idle counter parks the block in a SLEEP state and holds Y. Sits between operand sources and downstream datapath logic.
// PARAMETERS
// - N            4   number of input channels (>=2)
// - W            8   data width per channel (>=1)
// - IDLE_CYCLES  8   consecutive no-accept cycles in RUN before entering SLEEP (>=1)
// - WAKE_CYCLES  2   cycles spent in WAKE before in_ready reasserts (>=1)
// - localparam SELW = (N<=2) ? 1 : $clog2(N)
// PORTS
// - PwrClk    in   1     pulsed power clock; all state updates on rising edge
// - Rst       in   1     synchronous, active-high reset
// - In        in   N*W   packed channels; channel k = In[k*W +: W]
// - sel       in   SELW  channel select, sampled on accept
// - in_valid  in   1     request valid
// - in_ready  out  1     block accepts this cycle (combinational from state)
// - Y         out  W     registered mux output
// - y_valid   out  1     one-cycle pulse: Y reflects the last accepted request
// - sel_err   out  1     one-cycle pulse: accepted sel >= N
// - sleep     out  1     high while state == SLEEP
// BEHAVIOUR
// - Clock and reset: one clock, PwrClk. Reset Rst is synchronous and active-high.
// - Reset values: Y=0, y_valid=0, sel_err=0, state=RUN, idle_cnt=0, act_cnt=0. in_ready is forced 0 while Rst=1.
// - States: RUN, SLEEP, WAKE. in_ready = (state==RUN) && !Rst. sleep = (state==SLEEP).
// - Accept: accept = in_valid && in_ready.
// - Result: on an accept at edge t, Y and y_valid are updated at edge t+1. Latency is 1 cycle.
// - Data gating: on accept with sel<N and In[sel] != Y, Y <= In[sel]. With In[sel] == Y, Y is not written, but y_valid still pulses.
// - Invalid select: on accept with sel>=N, Y holds. y_valid=1 and sel_err=1 for one cycle.
// - Idle counting in RUN: accept clears idle_cnt. Otherwise idle_cnt increments, saturating at IDLE_CYCLES.
// - RUN->SLEEP: when idle_cnt reaches IDLE_CYCLES, i.e. after IDLE_CYCLES consecutive non-accept cycles. The last of those cycles still shows in_ready=1.
// - SLEEP: Y holds, y_valid=0, in_ready=0. in_valid=1 moves to WAKE on the next edge. The request is not accepted and must be held by the source.
// - WAKE: counts WAKE_CYCLES cycles, then goes to RUN with idle_cnt=0. in_ready=0 throughout WAKE.
// - Simultaneous events: an accept in the same cycle idle_cnt would saturate takes priority. idle_cnt clears and the state stays RUN.
// - Reset mid-operation: Rst in any state returns to RUN at the next edge. Pending y_valid and sel_err pulses are dropped; Y=0.
// - Source rule: in_valid may drop without an accept. No data is lost, because capture only occurs on accept.
// CONFIGURATION
// - Macro MUX_LP_ACT_CNT_EN, when defined:
//   - Adds output act_cnt (out, 16).
//   - act_cnt increments on each actual Y register write, i.e. a value change; saturates at 16'hFFFF.
//   - Rst clears act_cnt.
// - Macro not defined: the act_cnt port and counter are absent. All other behaviour is identical.
// TESTING (N=4, W=8, IDLE_CYCLES=8, WAKE_CYCLES=2)
// - 1 Reset: Rst=1 for 2 edges with in_valid=1 -> Y=8'h00, in_ready=0, y_valid=0, sleep=0. First cycle after release: in_ready=1.
// - 2 Channel sweep: In={8'hD4,8'hC3,8'hB2,8'hA1}, accept sel=0,1,2,3 on consecutive cycles
//     -> Y=A1,B2,C3,D4 each one edge after its accept; y_valid high 4 cycles.
//     -> act_cnt=4 when MUX_LP_ACT_CNT_EN is defined.
// - 3 Data gating: accept sel=1 twice with In[1]=8'hB2 -> y_valid pulses twice; Y=B2; act_cnt increments only once.
// - 4 Sleep/wake: 8 idle cycles -> sleep=1, in_ready=0.
//     -> Then in_valid=1, sel=2 held -> 1 edge to WAKE, 2 WAKE cycles, then in_ready=1 and accept; Y=C3 the edge after.
// - 5 Boundary: accept on the 8th idle cycle -> no SLEEP, idle_cnt=0.
//     -> Separately, a sel out of range -> sel_err=1 and Y unchanged. Needs N=3 to be reachable, since sel=3 is a valid channel at N=4.
// - 6 Reset mid-WAKE: assert Rst while in WAKE -> RUN after the edge; Y=0, act_cnt=0, no y_valid pulse.

Source files
------------

// File: rtl/mux_lp_nch.sv
`default_nettype none
// ============================================================================
// Module   : mux_lp_nch
// Purpose  : N-channel, W-bit low-power multiplexer with a registered,
//            data-gated output and a valid/ready request handshake. An idle
//            counter parks the block in SLEEP (output held) until a new
//            request arrives, then a short WAKE period precedes RUN.
// Ports    : PwrClk   - clock, all state updates on its rising edge
//            Rst      - synchronous, active-high reset
//            In       - N packed channels, channel k = In[k*W +: W]
//            sel      - channel select, sampled on accept
//            in_valid - request valid
//            in_ready - request accepted this cycle (RUN and not in reset)
//            Y        - registered mux output
//            y_valid  - one-cycle pulse, Y reflects last accepted request
//            sel_err  - one-cycle pulse, accepted sel was >= N
//            sleep    - high while parked in SLEEP
//            act_cnt  - (MUX_LP_ACT_CNT_EN only) saturating count of Y writes
// Config   : define MUX_LP_ACT_CNT_EN to add the act_cnt port and counter.
// Revision : 1.0 - initial release
// ============================================================================
module mux_lp_nch #(
  parameter int unsigned N           = 4,
  parameter int unsigned W           = 8,
  parameter int unsigned IDLE_CYCLES = 8,
  parameter int unsigned WAKE_CYCLES = 2,
  localparam int unsigned SELW       = (N <= 2) ? 1 : $clog2(N)
) (
  input  logic            PwrClk,
  input  logic            Rst,
  input  logic [N*W-1:0]  In,
  input  logic [SELW-1:0] sel,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [W-1:0]    Y,
  output logic            y_valid,
  output logic            sel_err,
  output logic            sleep
`ifdef MUX_LP_ACT_CNT_EN
  ,output logic [15:0]    act_cnt
`endif
);

  localparam int unsigned IDW = $clog2(IDLE_CYCLES + 1);
  localparam int unsigned WKW = $clog2(WAKE_CYCLES + 1);

  localparam logic [1:0] c_run   = 2'd0;
  localparam logic [1:0] c_sleep = 2'd1;
  localparam logic [1:0] c_wake  = 2'd2;

  logic [1:0]     state_q,    state_d;
  logic [IDW-1:0] idle_cnt_q, idle_cnt_d;
  logic [WKW-1:0] wake_cnt_q, wake_cnt_d;
  logic [W-1:0]   y_q,        y_d;
  logic           y_valid_q,  y_valid_d;
  logic           sel_err_q,  sel_err_d;
  logic [15:0]    act_cnt_q,  act_cnt_d;

  logic [W-1:0]   w_sel_data;
  logic           w_sel_ok;
  logic           w_accept;
  logic           w_y_write;

  // Channel extraction; out-of-range selects yield zero but are never written.
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (sel == SELW'(k)) w_sel_data = In[k*W +: W];
    end
  end

  // Widened by one bit so the compare stays meaningful when N is a power of two.
  assign w_sel_ok  = ({1'b0, sel} < (SELW+1)'(N));
  assign w_accept  = in_valid && in_ready;
  // Data gating: the output register is only clocked with new data on a change.
  assign w_y_write = w_accept && w_sel_ok && (w_sel_data != y_q);

  // State register
  always_ff @(posedge PwrClk) begin
    if (Rst) begin
      state_q    <= c_run;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      y_q        <= '0;
      y_valid_q  <= 1'b0;
      sel_err_q  <= 1'b0;
      act_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      y_q        <= y_d;
      y_valid_q  <= y_valid_d;
      sel_err_q  <= sel_err_d;
      act_cnt_q  <= act_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    case (state_q)
      c_run: begin
        if (w_accept) begin
          idle_cnt_d = '0;
        end else begin
          if (idle_cnt_q != IDW'(IDLE_CYCLES)) idle_cnt_d = idle_cnt_q + 1'b1;
          // Leave RUN on the edge that closes the last idle cycle, so that
          // cycle itself still advertised in_ready.
          if (idle_cnt_d == IDW'(IDLE_CYCLES)) state_d = c_sleep;
        end
      end
      c_sleep: begin
        // The request is not taken here; the source keeps it asserted.
        if (in_valid) begin
          state_d    = c_wake;
          wake_cnt_d = '0;
        end
      end
      c_wake: begin
        if (wake_cnt_q == WKW'(WAKE_CYCLES - 1)) begin
          state_d    = c_run;
          idle_cnt_d = '0;
          wake_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = c_run;
        idle_cnt_d = '0;
        wake_cnt_d = '0;
      end
    endcase
  end

  // Output / datapath logic
  always_comb begin
    in_ready  = (state_q == c_run) && !Rst;
    sleep     = (state_q == c_sleep);
    y_d       = w_y_write ? w_sel_data : y_q;
    y_valid_d = w_accept;
    sel_err_d = w_accept && !w_sel_ok;
    act_cnt_d = act_cnt_q;
    if (w_y_write && (act_cnt_q != 16'hFFFF)) act_cnt_d = act_cnt_q + 16'd1;
  end

  assign Y       = y_q;
  assign y_valid = y_valid_q;
  assign sel_err = sel_err_q;

`ifdef MUX_LP_ACT_CNT_EN
  assign act_cnt = act_cnt_q;
`else
  // Counter has no observer in this build; synthesis removes it.
  logic w_unused_act;
  assign w_unused_act = ^act_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_lp_nch.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_lp_nch
// Purpose  : Directed self-checking bench for mux_lp_nch (N=4 instance plus an
//            N=3 instance used to reach an out-of-range select).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_lp_nch;

  logic        clk;
  logic        Rst;
  logic [31:0] In;
  logic [1:0]  sel;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  Y;
  logic        y_valid;
  logic        sel_err;
  logic        sleep;

  logic [23:0] In3;
  logic [1:0]  sel3;
  logic        in_valid3;
  logic        in_ready3;
  logic [7:0]  Y3;
  logic        y_valid3;
  logic        sel_err3;
  logic        sleep3;

`ifdef MUX_LP_ACT_CNT_EN
  logic [15:0] act_cnt;
  logic [15:0] act_cnt3;
`endif

  int n_vec;
  int n_err;

  mux_lp_nch #(.N(4), .W(8), .IDLE_CYCLES(8), .WAKE_CYCLES(2)) dut (
    .PwrClk(clk), .Rst(Rst), .In(In), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .Y(Y), .y_valid(y_valid), .sel_err(sel_err),
    .sleep(sleep)
`ifdef MUX_LP_ACT_CNT_EN
    , .act_cnt(act_cnt)
`endif
  );

  mux_lp_nch #(.N(3), .W(8), .IDLE_CYCLES(8), .WAKE_CYCLES(2)) dut3 (
    .PwrClk(clk), .Rst(Rst), .In(In3), .sel(sel3), .in_valid(in_valid3),
    .in_ready(in_ready3), .Y(Y3), .y_valid(y_valid3), .sel_err(sel_err3),
    .sleep(sleep3)
`ifdef MUX_LP_ACT_CNT_EN
    , .act_cnt(act_cnt3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs are then driven, outputs sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b1; in_valid = 1'b1; sel = 2'd1; In = 32'hD4C3B2A1;
    tick(); tick();
    n_vec++; if (Y !== 8'h00) begin n_err++; $display("FAIL reset_y: got %h want 00", Y); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", in_ready); end
    n_vec++; if (y_valid !== 1'b0) begin n_err++; $display("FAIL reset_yvalid: got %b want 0", y_valid); end
    n_vec++; if (sleep !== 1'b0) begin n_err++; $display("FAIL reset_sleep: got %b want 0", sleep); end
    Rst = 1'b0; in_valid = 1'b0;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_sel_err();
    logic [7:0] exp_y [3];
    exp_y[0] = 8'hA1; exp_y[1] = 8'hB2; exp_y[2] = 8'hC3;
    In3 = 24'hC3B2A1; in_valid3 = 1'b1; sel3 = 2'd2;
    tick();
    n_vec++; if (Y3 !== exp_y[2]) begin n_err++; $display("FAIL n3_y: got %h want %h", Y3, exp_y[2]); end
    n_vec++; if (sel_err3 !== 1'b0) begin n_err++; $display("FAIL n3_selerr_ok: got %b want 0", sel_err3); end
    sel3 = 2'd3;
    tick();
    n_vec++; if (sel_err3 !== 1'b1) begin n_err++; $display("FAIL n3_selerr: got %b want 1", sel_err3); end
    n_vec++; if (y_valid3 !== 1'b1) begin n_err++; $display("FAIL n3_yvalid: got %b want 1", y_valid3); end
    n_vec++; if (Y3 !== exp_y[2]) begin n_err++; $display("FAIL n3_hold: got %h want %h", Y3, exp_y[2]); end
    in_valid3 = 1'b0;
    tick();
    n_vec++; if (sel_err3 !== 1'b0) begin n_err++; $display("FAIL n3_selerr_pulse: got %b want 0", sel_err3); end
  endtask

  task automatic test_sweep();
    logic [7:0] exp_y [4];
    exp_y[0] = 8'hA1; exp_y[1] = 8'hB2; exp_y[2] = 8'hC3; exp_y[3] = 8'hD4;
    In = 32'hD4C3B2A1; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k);
      tick();
      n_vec++; if (Y !== exp_y[k]) begin n_err++; $display("FAIL sweep_y%0d: got %h want %h", k, Y, exp_y[k]); end
      n_vec++; if (y_valid !== 1'b1) begin n_err++; $display("FAIL sweep_yv%0d: got %b want 1", k, y_valid); end
    end
    in_valid = 1'b0;
    tick();
    n_vec++; if (y_valid !== 1'b0) begin n_err++; $display("FAIL sweep_yv_end: got %b want 0", y_valid); end
`ifdef MUX_LP_ACT_CNT_EN
    n_vec++; if (act_cnt !== 16'd4) begin n_err++; $display("FAIL sweep_act: got %0d want 4", act_cnt); end
`endif
  endtask

  task automatic test_gating();
    in_valid = 1'b1; sel = 2'd1;
    tick();
    n_vec++; if (Y !== 8'hB2) begin n_err++; $display("FAIL gate_y1: got %h want b2", Y); end
    n_vec++; if (y_valid !== 1'b1) begin n_err++; $display("FAIL gate_yv1: got %b want 1", y_valid); end
`ifdef MUX_LP_ACT_CNT_EN
    n_vec++; if (act_cnt !== 16'd5) begin n_err++; $display("FAIL gate_act1: got %0d want 5", act_cnt); end
`endif
    tick();
    n_vec++; if (Y !== 8'hB2) begin n_err++; $display("FAIL gate_y2: got %h want b2", Y); end
    n_vec++; if (y_valid !== 1'b1) begin n_err++; $display("FAIL gate_yv2: got %b want 1", y_valid); end
`ifdef MUX_LP_ACT_CNT_EN
    n_vec++; if (act_cnt !== 16'd5) begin n_err++; $display("FAIL gate_act2: got %0d want 5", act_cnt); end
`endif
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_sleep_wake();
    // Fresh accept so the idle count starts from zero.
    in_valid = 1'b1; sel = 2'd3;
    tick();
    n_vec++; if (Y !== 8'hD4) begin n_err++; $display("FAIL sw_pre_y: got %h want d4", Y); end
    in_valid = 1'b0;
    repeat (7) tick();
    n_vec++; if (sleep !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL sw_idle7: got sleep=%b ready=%b want 0/1", sleep, in_ready); end
    tick();
    n_vec++; if (sleep !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL sw_sleep: got sleep=%b ready=%b want 1/0", sleep, in_ready); end
    in_valid = 1'b1; sel = 2'd2;
    tick();
    n_vec++; if (sleep !== 1'b0 || in_ready !== 1'b0) begin n_err++; $display("FAIL sw_wake1: got sleep=%b ready=%b want 0/0", sleep, in_ready); end
    n_vec++; if (Y !== 8'hD4) begin n_err++; $display("FAIL sw_wake_hold: got %h want d4", Y); end
    tick();
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL sw_wake2: got ready=%b want 0", in_ready); end
    tick();
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL sw_run: got ready=%b want 1", in_ready); end
    n_vec++; if (y_valid !== 1'b0) begin n_err++; $display("FAIL sw_noyv: got %b want 0", y_valid); end
    tick();
    n_vec++; if (Y !== 8'hC3 || y_valid !== 1'b1) begin n_err++; $display("FAIL sw_accept: got y=%h yv=%b want c3/1", Y, y_valid); end
    in_valid = 1'b0;
  endtask

  task automatic test_boundary();
    in_valid = 1'b1; sel = 2'd0;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    in_valid = 1'b1; sel = 2'd1;
    tick();
    n_vec++; if (sleep !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL bnd_nosleep: got sleep=%b ready=%b want 0/1", sleep, in_ready); end
    n_vec++; if (Y !== 8'hB2 || y_valid !== 1'b1) begin n_err++; $display("FAIL bnd_accept: got y=%h yv=%b want b2/1", Y, y_valid); end
    in_valid = 1'b0;
    repeat (7) tick();
    n_vec++; if (sleep !== 1'b0) begin n_err++; $display("FAIL bnd_idle_cleared: got sleep=%b want 0", sleep); end
    tick();
    n_vec++; if (sleep !== 1'b1) begin n_err++; $display("FAIL bnd_sleep: got sleep=%b want 1", sleep); end
  endtask

  task automatic test_reset_wake();
    in_valid = 1'b1; sel = 2'd3;
    tick();
    n_vec++; if (sleep !== 1'b0 || in_ready !== 1'b0) begin n_err++; $display("FAIL rw_in_wake: got sleep=%b ready=%b want 0/0", sleep, in_ready); end
    Rst = 1'b1;
    tick();
    Rst = 1'b0; in_valid = 1'b0;
    #1;
    n_vec++; if (in_ready !== 1'b1 || sleep !== 1'b0) begin n_err++; $display("FAIL rw_run: got ready=%b sleep=%b want 1/0", in_ready, sleep); end
    n_vec++; if (Y !== 8'h00) begin n_err++; $display("FAIL rw_y: got %h want 00", Y); end
`ifdef MUX_LP_ACT_CNT_EN
    n_vec++; if (act_cnt !== 16'd0) begin n_err++; $display("FAIL rw_act: got %0d want 0", act_cnt); end
`endif
    tick();
    n_vec++; if (y_valid !== 1'b0) begin n_err++; $display("FAIL rw_noyv: got %b want 0", y_valid); end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    Rst = 1'b1; In = '0; sel = '0; in_valid = 1'b0;
    In3 = '0; sel3 = '0; in_valid3 = 1'b0;
    test_reset();
    test_sel_err();
    test_sweep();
    test_gating();
    test_sleep_wake();
    test_boundary();
    test_reset_wake();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
